// File: rtl/cdc_pulse_handshake.sv
// cdc_pulse_handshake
// Moves a single-cycle event plus payload from src_clk to dst_clk using a
// toggle request/acknowledge handshake. The source holds the payload stable
// and refuses new events until the destination acknowledges, so events are
// never merged or silently lost; rejected events are reported on src_drop.
`timescale 1ps/1ps

module cdc_pulse_handshake #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2     // must be >= 2
) (
    // source domain
    input  logic              src_clk,
    input  logic              src_rst_n,
    input  logic              src_pulse,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_busy,
    output logic              src_done,
    output logic              src_drop,
    // destination domain
    input  logic              dst_clk,
    input  logic              dst_rst_n,
    output logic              dst_pulse,
    output logic [DATA_W-1:0] dst_data
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Source domain state
    // ------------------------------------------------------------------
    state_t                 state_reg;
    logic                   req_tgl_reg;
    logic [DATA_W-1:0]      src_hold_reg;
    logic [SYNC_STAGES-1:0] ack_sync_reg;
    logic                   ack_sync;

    // ------------------------------------------------------------------
    // Destination domain state
    // ------------------------------------------------------------------
    logic                   ack_tgl_reg;
    logic [SYNC_STAGES-1:0] req_sync_reg;
    logic                   req_sync;

    assign ack_sync = ack_sync_reg[SYNC_STAGES-1];
    assign req_sync = req_sync_reg[SYNC_STAGES-1];

    // Bring the destination's acknowledge toggle into src_clk.
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            ack_sync_reg <= '0;
        end else begin
            ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], ack_tgl_reg};
        end
    end

    // Source handshake FSM: accept one event, hold payload, wait for ack.
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            state_reg    <= IDLE;
            req_tgl_reg  <= 1'b0;
            src_hold_reg <= '0;
            src_busy     <= 1'b0;
            src_done     <= 1'b0;
            src_drop     <= 1'b0;
        end else begin
            src_done <= 1'b0;
            src_drop <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (src_pulse) begin
                        src_hold_reg <= src_data;
                        req_tgl_reg  <= ~req_tgl_reg;
                        state_reg    <= WAIT_ACK;
                        src_busy     <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // Any event while a transfer is open is rejected, even on
                    // the cycle the acknowledge lands; the payload register
                    // must not move until the FSM is back in IDLE.
                    if (src_pulse) begin
                        src_drop <= 1'b1;
                    end
                    if (ack_sync == req_tgl_reg) begin
                        state_reg <= IDLE;
                        src_busy  <= 1'b0;
                        src_done  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    src_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Bring the source's request toggle into dst_clk.
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            req_sync_reg <= '0;
        end else begin
            req_sync_reg <= {req_sync_reg[SYNC_STAGES-2:0], req_tgl_reg};
        end
    end

    // Detect a new request, capture the held payload and acknowledge it.
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            ack_tgl_reg <= 1'b0;
            dst_pulse   <= 1'b0;
            dst_data    <= '0;
        end else begin
            // src_hold_reg is static while the request is outstanding, so it
            // is safe to sample directly once the toggle has been synchronised.
            if (req_sync != ack_tgl_reg) begin
                ack_tgl_reg <= req_sync;
                dst_data    <= src_hold_reg;
                dst_pulse   <= 1'b1;
            end else begin
                dst_pulse   <= 1'b0;
            end
        end
    end

endmodule
